// File: rtl/seu_uart_reporter.sv
// Reports the SEU count as a 6-byte 8N1 UART frame: A5, count MSB..LSB, XOR checksum.
// Frames are triggered by a free-running period timer or by report_req; one trigger can be held pending.
module seu_uart_reporter #(
   parameter int CLKS_PER_BIT  = 868,
   parameter int REPORT_PERIOD = 100000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ctr_in,
   input  logic        report_req,
   output logic        tx,
   output logic        busy,
   output logic [15:0] frame_cnt
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int TW = $clog2(REPORT_PERIOD);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [2:0]    byte_q, byte_d;
   logic [31:0]   snap_q, snap_d;
   logic [7:0]    chk_q, chk_d;
   logic          pend_q, pend_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          tick, trig, bit_end;
   logic [7:0]    cur_byte;

   assign tick    = (timer_q == TW'(REPORT_PERIOD - 1));
   assign timer_d = tick ? '0 : timer_q + TW'(1);
   assign trig    = tick | report_req;
   assign bit_end = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      snap_d  = snap_q;
      chk_d   = chk_q;
      pend_d  = pend_q | trig;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         IDLE: begin
            if (trig || pend_q) begin
               snap_d  = ctr_in;
               chk_d   = ctr_in[31:24] ^ ctr_in[23:16] ^ ctr_in[15:8] ^ ctr_in[7:0];
               byte_d  = 3'd0;
               bit_d   = 3'd0;
               // One extra start-bit cycle covers the registered-output lag at frame start.
               cnt_d   = CW'(CLKS_PER_BIT);
               pend_d  = pend_q & trig;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = CW'(CLKS_PER_BIT - 1);
               bit_d   = 3'd0;
               state_d = DATA;
            end else cnt_d = cnt_q - CW'(1);
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = CW'(CLKS_PER_BIT - 1);
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end else cnt_d = cnt_q - CW'(1);
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = CW'(CLKS_PER_BIT - 1);
               if (byte_q < 3'd5) begin
                  byte_d  = byte_q + 3'd1;
                  state_d = START;
               end else begin
                  fcnt_d  = fcnt_q + 16'd1;
                  state_d = IDLE;
               end
            end else cnt_d = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      case (byte_d)
         3'd0:    cur_byte = 8'hA5;
         3'd1:    cur_byte = snap_q[31:24];
         3'd2:    cur_byte = snap_q[23:16];
         3'd3:    cur_byte = snap_q[15:8];
         3'd4:    cur_byte = snap_q[7:0];
         3'd5:    cur_byte = chk_q;
         default: cur_byte = 8'hA5;
      endcase
   end

   // Outputs follow the next state, except they hold idle on the accept cycle itself.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_q != IDLE) && (state_d != IDLE);
      if (state_q != IDLE) begin
         case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         snap_q  <= '0;
         chk_q   <= '0;
         pend_q  <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         fcnt_q  <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         snap_q  <= snap_d;
         chk_q   <= chk_d;
         pend_q  <= pend_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         fcnt_q  <= fcnt_d;
         timer_q <= timer_d;
      end
   end

   assign tx        = tx_q;
   assign busy      = busy_q;
   assign frame_cnt = fcnt_q;
endmodule

// File: tb/tb_seu_uart_reporter.sv
// Directed bench for seu_uart_reporter with CLKS_PER_BIT=4, REPORT_PERIOD=10000.
module tb_seu_uart_reporter;
   logic        clk;
   logic        rst_n;
   logic [31:0] ctr_in;
   logic        report_req;
   logic        tx;
   logic        busy;
   logic [15:0] frame_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   seu_uart_reporter #(.CLKS_PER_BIT(4), .REPORT_PERIOD(10000)) dut (
      .clk(clk), .rst_n(rst_n), .ctr_in(ctr_in), .report_req(report_req),
      .tx(tx), .busy(busy), .frame_cnt(frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0; report_req = 1'b0; ctr_in = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_req();
      @(negedge clk); report_req = 1'b1;
      @(negedge clk); report_req = 1'b0;
   endtask

   task automatic pulse_after(input int d);
      repeat (d) @(negedge clk);
      report_req = 1'b1;
      @(negedge clk); report_req = 1'b0;
   endtask

   task automatic wait_start(input int maxc, output int n);
      n = 0;
      while (tx !== 1'b0 && n < maxc) begin
         @(negedge clk); n++;
      end
   endtask

   // Starts at the first negedge of a start bit; ends at the first negedge after the frame.
   task automatic check_frame(input logic [47:0] exp, input string nm);
      logic [47:0] obs;
      int bad, nbusy, m, j;
      logic eb;
      obs = '0; bad = 0; nbusy = 0;
      for (int s = 0; s < 60; s++) begin
         for (int c = 0; c < 4; c++) begin
            m = s / 10; j = s % 10;
            if (j == 0)      eb = 1'b0;
            else if (j == 9) eb = 1'b1;
            else             eb = exp[40 - 8*m + j - 1];
            if (c == 1 && j > 0 && j < 9) obs[40 - 8*m + j - 1] = tx;
            if (tx !== eb) bad++;
            if (busy !== 1'b1) nbusy++;
            @(negedge clk);
         end
      end
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s_bytes: got %h expected %h", nm, obs, exp); end
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL %s_bitcells: %0d wrong tx samples, expected 0", nm, bad); end
      n_chk++;
      if (nbusy != 0) begin n_fail++; $display("FAIL %s_busy: %0d samples low, expected 0", nm, nbusy); end
      n_chk++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++; $display("FAIL %s_end: busy=%b tx=%b expected busy=0 tx=1", nm, busy, tx);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; report_req = 1'b0; ctr_in = '0;
      #12;
      n_chk++;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_cnt !== 16'h0) begin
         n_fail++; $display("FAIL reset_state: tx=%b busy=%b cnt=%h expected 1 0 0000", tx, busy, frame_cnt);
      end
      do_reset();
      repeat (20) @(negedge clk);
      n_chk++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: tx=%b busy=%b expected 1 0", tx, busy);
      end
   endtask

   task automatic test_basic();
      int n;
      ctr_in = 32'h12345678;
      send_req();
      n_chk++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL basic_accept_cycle: tx=%b busy=%b expected 1 0", tx, busy);
      end
      wait_start(20, n);
      n_chk++;
      if (n != 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected 1", n); end
      check_frame(48'hA5_12_34_56_78_08, "basic");
      n_chk++;
      if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_cnt: got %h expected 0001", frame_cnt); end
   endtask

   task automatic test_tick();
      int n;
      do_reset();
      wait_start(10100, n);
      n_chk++;
      if (n != 10001) begin n_fail++; $display("FAIL tick_first: got %0d expected 10001", n); end
      check_frame(48'hA5_00_00_00_00_00, "tick");
      wait_start(10100, n);
      n_chk++;
      if (n != 9760) begin n_fail++; $display("FAIL tick_period: got %0d expected 9760", n); end
   endtask

   task automatic test_snapshot();
      int n;
      do_reset();
      ctr_in = 32'h00000001;
      send_req();
      wait_start(20, n);
      fork
         check_frame(48'hA5_00_00_00_01_01, "snapshot");
         begin repeat (90) @(negedge clk); ctr_in = 32'hFFFFFFFF; end
      join
      ctr_in = '0;
   endtask

   task automatic test_pending();
      int n;
      do_reset();
      ctr_in = 32'hCAFEBABE;
      send_req();
      wait_start(20, n);
      fork
         check_frame(48'hA5_CA_FE_BA_BE_30, "pend_first");
         begin pulse_after(20); pulse_after(80); pulse_after(100); end
      join
      wait_start(20, n);
      n_chk++;
      if (n != 2) begin n_fail++; $display("FAIL pend_gap: got %0d expected 2", n); end
      check_frame(48'hA5_CA_FE_BA_BE_30, "pend_second");
      n_chk++;
      if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL pend_cnt: got %h expected 0002", frame_cnt); end
      wait_start(300, n);
      n_chk++;
      if (n != 300 || tx !== 1'b1) begin
         n_fail++; $display("FAIL pend_no_third: waited %0d tx=%b expected 300 1", n, tx);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      ctr_in = 32'h0BADF00D;
      send_req();
      wait_start(20, n);
      repeat (130) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_cnt !== 16'h0) begin
         n_fail++; $display("FAIL midreset_async: tx=%b busy=%b cnt=%h expected 1 0 0000", tx, busy, frame_cnt);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      send_req();
      wait_start(20, n);
      n_chk++;
      if (n != 1) begin n_fail++; $display("FAIL midreset_latency: got %0d expected 1", n); end
      check_frame(48'hA5_0B_AD_F0_0D_5B, "midreset");
      n_chk++;
      if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL midreset_cnt: got %h expected 0001", frame_cnt); end
   endtask

   task automatic test_cnt_wrap();
      int n;
      @(negedge clk);
      force dut.fcnt_q = 16'hFFFF;
      @(negedge clk);
      release dut.fcnt_q;
      @(negedge clk);
      n_chk++;
      if (frame_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", frame_cnt); end
      ctr_in = 32'h11223344;
      send_req();
      wait_start(20, n);
      check_frame(48'hA5_11_22_33_44_44, "wrap");
      n_chk++;
      if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_cnt: got %h expected 0000", frame_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tick();
      test_snapshot();
      test_pending();
      test_reset_mid();
      test_cnt_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
